// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, multi-cycle data memory,
// HI/LO busy and taken-branch hazards, resolved by fixed priority into freeze/flush controls.
module pipeline_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MULT_LAT    = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_uses_hilo,
    input  logic             id_mult_start,
    input  logic             id_branch_tkn,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             id_ex_freeze,
    output logic             ex_mem_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mult_busy,
    output logic             mem_timeout
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } memState_e;

    localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(MEM_TIMEOUT);

    memState_e        memState_q, memState_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0] busyCnt_q, busyCnt_d;
    logic             timeout_q, timeout_d;

    logic memStall;
    logic srcHit;
    logic loadUse;
    logic multBusy;
    logic hiloStall;
    logic idAdvance;
    logic multAccept;

    // Hazard detection, each lower-priority hazard masked by all higher ones.
    always_comb begin
        memStall   = (memState_q == MEM_WAIT) || (mem_req && !mem_ready);
        srcHit     = (id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd));
        loadUse    = !memStall && ex_mem_read && (ex_rd != '0) && srcHit;
        multBusy   = (busyCnt_q != '0);
        hiloStall  = !memStall && !loadUse && id_uses_hilo && multBusy;
        idAdvance  = !memStall && !loadUse && !hiloStall;
        multAccept = idAdvance && id_mult_start && !multBusy;
    end

    // Outputs are gated by rst_b so that nothing leaks out while reset is held.
    always_comb begin
        pc_freeze     = rst_b && (memStall || loadUse || hiloStall);
        if_id_freeze  = rst_b && (memStall || loadUse || hiloStall);
        id_ex_freeze  = rst_b && memStall;
        ex_mem_freeze = rst_b && memStall;
        mem_wb_flush  = rst_b && memStall;
        id_ex_flush   = rst_b && (loadUse || hiloStall);
        if_id_flush   = rst_b && idAdvance && id_branch_tkn;
        mult_busy     = rst_b && multBusy;
        mem_timeout   = rst_b && timeout_q;
    end

    always_comb begin
        memState_d = memState_q;
        waitCnt_d  = waitCnt_q;
        case (memState_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    memState_d = MEM_WAIT;
                    waitCnt_d  = CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    memState_d = RUN;
                    waitCnt_d  = '0;
                end else if (waitCnt_q != '1) begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            default: begin
                memState_d = RUN;
                waitCnt_d  = '0;
            end
        endcase
        timeout_d = timeout_q || ((memState_d == MEM_WAIT) && (waitCnt_d >= TIMEOUT_C));
    end

    // HI/LO occupancy freezes along with the rest of the pipe during a memory stall.
    always_comb begin
        busyCnt_d = busyCnt_q;
        if (!memStall) begin
            if (multAccept) begin
                busyCnt_d = MULT_LAT_C;
            end else if (multBusy) begin
                busyCnt_d = busyCnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            memState_q <= RUN;
            waitCnt_q  <= '0;
            busyCnt_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            memState_q <= memState_d;
            waitCnt_q  <= waitCnt_d;
            busyCnt_q  <= busyCnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each cycle's expected output vector is queued when
// stimulus is driven and popped/compared at the following falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;

    // Output vector bit order: pc_fz, ifid_fz, idex_fz, exmem_fz, ifid_fl, idex_fl, memwb_fl, busy, tmo
    localparam logic [8:0] IDLE  = 9'b000000000;
    localparam logic [8:0] LU    = 9'b110001000;
    localparam logic [8:0] MEM   = 9'b111100100;
    localparam logic [8:0] BR    = 9'b000010000;
    localparam logic [8:0] BUSY  = 9'b000000010;
    localparam logic [8:0] TMO   = 9'b000000001;

    logic             clk;
    logic             rst_b;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rs, id_uses_rt, id_uses_hilo, id_mult_start, id_branch_tkn;
    logic             ex_mem_read, mem_req, mem_ready;
    logic             pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, mult_busy, mem_timeout;
    logic [8:0]       outVec;

    int compareCount = 0;
    int failCount    = 0;

    logic [8:0] expQ[$];
    string      tagQ[$];

    pipeline_hazard_ctrl #(
        .REG_W(REG_W), .MULT_LAT(3), .MEM_TIMEOUT(4), .CNT_W(8)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_uses_hilo(id_uses_hilo), .id_mult_start(id_mult_start),
        .id_branch_tkn(id_branch_tkn), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .id_ex_freeze(id_ex_freeze),
        .ex_mem_freeze(ex_mem_freeze), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush), .mult_busy(mult_busy), .mem_timeout(mem_timeout)
    );

    assign outVec = {pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
                     if_id_flush, id_ex_flush, mem_wb_flush, mult_busy, mem_timeout};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time limit expired, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Queue the expectation, compare at the falling edge, return just after the next rising edge.
    task automatic applyStimulus(input string tag, input logic [8:0] expected);
        logic [8:0] e;
        string      t;
        expQ.push_back(expected);
        tagQ.push_back(tag);
        @(negedge clk);
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(t, outVec, e);
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0; id_mult_start = 0;
        id_branch_tkn = 0; ex_mem_read = 0; mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        rst_b = 1'b0;
        clearInputs();
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        mem_req = 1; id_branch_tkn = 1;
        applyStimulus("reset_forces_zero", IDLE);
        rst_b = 1'b1;
        clearInputs();
        applyStimulus("idle_after_reset", IDLE);

        // Load-use hazards
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        applyStimulus("loaduse_rs", LU);
        ex_mem_read = 0;
        applyStimulus("loaduse_resolved", IDLE);
        clearInputs();
        ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1; id_rs = 5;
        applyStimulus("loaduse_rt", LU);
        id_uses_rt = 0;
        applyStimulus("match_unused", IDLE);
        clearInputs();
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        applyStimulus("rd_zero_no_stall", IDLE);
        clearInputs();

        // Branch flush and its suppression under a stall
        id_branch_tkn = 1;
        applyStimulus("branch_flush", BR);
        ex_mem_read = 1; ex_rd = 9; id_rs = 9; id_uses_rs = 1;
        applyStimulus("branch_under_loaduse", LU);
        ex_mem_read = 0;
        applyStimulus("branch_after_stall", BR);
        clearInputs();

        // Multi-cycle memory access: three waits then ready
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) applyStimulus("mem_wait", MEM);
        mem_ready = 1;
        applyStimulus("mem_ready_cycle", MEM);
        clearInputs();
        applyStimulus("mem_released", IDLE);
        mem_req = 1; mem_ready = 1;
        applyStimulus("mem_single_cycle", IDLE);
        mem_ready = 0; id_branch_tkn = 1;
        ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
        applyStimulus("mem_over_loaduse_branch", MEM);
        mem_ready = 1;
        applyStimulus("mem_over_all_done", MEM);
        clearInputs();

        // Mult followed by mfhi
        id_mult_start = 1; id_uses_hilo = 1;
        applyStimulus("mult_accept", IDLE);
        id_mult_start = 0;
        for (int i = 0; i < 3; i++) applyStimulus("mfhi_stall", LU | BUSY);
        applyStimulus("mfhi_issue", IDLE);
        clearInputs();

        // Mult counter frozen by a memory stall
        id_mult_start = 1; id_uses_hilo = 1;
        applyStimulus("mult_accept2", IDLE);
        clearInputs();
        mem_req = 1; mem_ready = 0;
        applyStimulus("mem_with_busy", MEM | BUSY);
        mem_ready = 1;
        applyStimulus("mem_done_with_busy", MEM | BUSY);
        clearInputs();
        id_uses_hilo = 1;
        for (int i = 0; i < 3; i++) applyStimulus("hilo_after_freeze", LU | BUSY);
        applyStimulus("hilo_clear", IDLE);
        clearInputs();

        // Mult start blocked by a load-use is not accepted
        id_mult_start = 1; id_uses_hilo = 1;
        ex_mem_read = 1; ex_rd = 4; id_rs = 4; id_uses_rs = 1;
        applyStimulus("mult_blocked", LU);
        clearInputs();
        applyStimulus("mult_not_started", IDLE);

        // Timeout: ready held low
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) applyStimulus("timeout_pending", MEM);
        applyStimulus("timeout_set", MEM | TMO);
        mem_ready = 1;
        applyStimulus("timeout_ready", MEM | TMO);
        clearInputs();
        applyStimulus("timeout_sticky", TMO);

        // Reset mid-MEM_WAIT and mid-mult
        mem_req = 1; mem_ready = 0;
        applyStimulus("rewait", MEM | TMO);
        rst_b = 1'b0;
        applyStimulus("reset_mid_wait", IDLE);
        rst_b = 1'b1;
        mem_req = 1; mem_ready = 1;
        applyStimulus("run_after_reset", IDLE);
        clearInputs();
        id_mult_start = 1; id_uses_hilo = 1;
        applyStimulus("mult_before_reset", IDLE);
        clearInputs();
        rst_b = 1'b0;
        id_uses_hilo = 1;
        applyStimulus("reset_mid_mult", IDLE);
        rst_b = 1'b1;
        applyStimulus("mult_abandoned", IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
